// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode constants and fetch FSM state type
// Purpose : opcode/funct encodings used by the fetch unit and the decoder,
//           the fetch sequencer state type, and a small opcode helper.
// Ports   : none (package).
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    ERROR = 2'd3
  } fetch_state_t;

  function automatic logic is_rtype(input logic [5:0] opcode);
    return opcode == OP_RTYPE;
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational next-PC priority mux and adders
// Purpose : picks the PC that follows the executing instruction.
//           Priority: jr (opcode-qualified) > jump > taken branch > pc+4.
// Ports   : pc, instr, rs_data, jump, branch, nequal, jr, alu_zero (in);
//           next_pc, pc4, jr_misaligned (out).
import mips_pkg::*;

module next_pc_sel #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic [31:0]       rs_data,
  input  logic              jump,
  input  logic              branch,
  input  logic              nequal,
  input  logic              jr,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc4,
  output logic              jr_misaligned
);

  logic              jr_q;
  logic              br_taken;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jr_tgt;
  logic [ADDR_W-1:0] j_tgt;

  assign pc4 = pc + ADDR_W'(4);

  // Control decodes Jr from funct alone; only trust it on R-type words.
  assign jr_q = jr && is_rtype(instr[31:26]);

  // bne flips the sense of the zero flag.
  assign br_taken = branch && (alu_zero ^ nequal);

  assign br_off = ADDR_W'({{14{instr[15]}}, instr[15:0], 2'b00});

  // A misaligned jr target is flagged but still followed word-aligned.
  assign jr_tgt        = ADDR_W'({rs_data[31:2], 2'b00});
  assign jr_misaligned = jr_q && (rs_data[1:0] != 2'b00);

  assign j_tgt = {pc4[ADDR_W-1:28], instr[25:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    if (jr_q) begin
      next_pc = jr_tgt;
    end else if (jump) begin
      next_pc = j_tgt;
    end else if (br_taken) begin
      next_pc = pc4 + br_off;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register and instruction-fetch sequencer
// Purpose : fetches the word at pc over im_req/im_ack, holds it in instr for
//           the decoder while instr_valid, then advances pc from the control
//           inputs. A fetch that waits TIMEOUT cycles for im_ack locks in ERROR.
// Ports   : clk, rst_n (async, active low);
//           im_req/im_addr/im_ack/im_rdata - instruction memory handshake;
//           instr/instr_valid - to Control; pc, link_addr (pc+4 for jal);
//           Jump/Branch/NEqual/Jal/Jr/alu_zero/rs_data - next-PC selection;
//           stall - holds EXEC; err - sticky timeout / misaligned jr flag.
import mips_pkg::*;

module instr_fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [31:0]       im_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  input  logic              Jump,
  input  logic              Branch,
  input  logic              NEqual,
  input  logic              Jal,
  input  logic              Jr,
  input  logic              alu_zero,
  input  logic [31:0]       rs_data,
  input  logic              stall,
  output logic              err
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;
  logic [7:0]        tcnt_q;
  logic              err_q;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] pc4;
  logic              jr_misaligned;

  // Control raises Jal together with Jump; either one selects the jump target.
  next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .pc            (pc_q),
    .instr         (instr_q),
    .rs_data       (rs_data),
    .jump          (Jump | Jal),
    .branch        (Branch),
    .nequal        (NEqual),
    .jr            (Jr),
    .alu_zero      (alu_zero),
    .next_pc       (next_pc),
    .pc4           (pc4),
    .jr_misaligned (jr_misaligned)
  );

  always_comb begin
    state_d     = state_q;
    im_req      = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        im_req = 1'b1;
        if (im_ack) begin
          state_d = EXEC;
        end else if (tcnt_q + 8'd1 == TMO) begin
          state_d = ERROR;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          state_d = FETCH;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counter only runs inside FETCH, so it is zero on every FETCH entry.
      if (state_q == FETCH) begin
        if (im_ack) begin
          instr_q <= im_rdata;
        end else begin
          tcnt_q <= tcnt_q + 8'd1;
        end
      end else begin
        tcnt_q <= '0;
      end
      if (state_q == EXEC && !stall) begin
        pc_q <= next_pc;
        if (jr_misaligned) begin
          err_q <= 1'b1;
        end
      end
      if (state_d == ERROR) begin
        err_q <= 1'b1;
      end
    end
  end

  // pc_q only ever loads word-aligned values, so bits [1:0] stay zero.
  assign pc        = pc_q;
  assign im_addr   = pc_q;
  assign link_addr = pc4;
  assign instr     = instr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        Jump = 1'b0, Branch = 1'b0, NEqual = 1'b0, Jal = 1'b0, Jr = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] rs_data = '0;
  logic        stall = 1'b0;
  logic        err;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .link_addr(link_addr),
    .Jump(Jump), .Branch(Branch), .NEqual(NEqual), .Jal(Jal), .Jr(Jr),
    .alu_zero(alu_zero), .rs_data(rs_data), .stall(stall), .err(err)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch unit should be doing, phase by phase.
  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_ERR = 3;
  int          m_phase = M_IDLE;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  logic        m_err = 1'b0;
  int          m_wait = 0;

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic [31:0] rs, input logic j, input logic b,
                                           input logic ne, input logic jr_i, input logic z);
    logic [31:0] p4;
    int imm;
    p4 = p + 32'd4;
    if (jr_i && ins[31:26] == 6'd0) return rs - (rs % 4);
    if (j) return (p4 & 32'hF000_0000) + 32'(ins[25:0]) * 4;
    if (b && (z != ne)) begin
      imm = int'($signed(ins[15:0]));
      return p4 + 32'(imm * 4);
    end
    return p4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = M_IDLE; m_pc = 32'h0; m_instr = '0; m_err = 1'b0; m_wait = 0;
    end else begin
      case (m_phase)
        M_IDLE: begin m_phase = M_FETCH; m_wait = 0; end
        M_FETCH: begin
          if (im_ack) begin
            m_instr = im_rdata; m_phase = M_EXEC;
          end else begin
            m_wait++;
            if (m_wait >= TMO) begin m_phase = M_ERR; m_err = 1'b1; end
          end
        end
        M_EXEC: begin
          if (!stall) begin
            if (Jr && m_instr[31:26] == 6'd0 && rs_data % 4 != 0) m_err = 1'b1;
            m_pc = ref_next(m_pc, m_instr, rs_data, Jump, Branch, NEqual, Jr, alu_zero);
            m_phase = M_FETCH; m_wait = 0;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("im_req", 32'(im_req), 32'(m_phase == M_FETCH));
      check("instr_valid", 32'(instr_valid), 32'(m_phase == M_EXEC));
      check("pc", pc, m_pc);
      check("im_addr", im_addr, m_pc);
      check("link_addr", link_addr, m_pc + 32'd4);
      check("err", 32'(err), 32'(m_err));
      if (m_phase == M_EXEC) check("instr", instr, m_instr);
    end
  end

  task automatic do_fetch(input logic [31:0] word, input logic [31:0] exp_addr,
                          input bit chk_addr, input string name);
    int n = 0;
    while (!im_req && n < 50) begin @(posedge clk); #1; n++; end
    if (!im_req) begin
      tests++; fails++;
      $display("FAIL %s: im_req not seen within 50 cycles", name);
    end else if (chk_addr) begin
      check(name, im_addr, exp_addr);
    end
    im_ack = 1'b1; im_rdata = word;
    @(posedge clk); #1;
    im_ack = 1'b0; im_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_exec(input logic j, input logic b, input logic ne, input logic jl,
                         input logic jr_i, input logic z, input logic [31:0] rs);
    Jump = j; Branch = b; NEqual = ne; Jal = jl; Jr = jr_i; alu_zero = z; rs_data = rs; stall = 1'b0;
    @(posedge clk); #1;
    Jump = 0; Branch = 0; NEqual = 0; Jal = 0; Jr = 0; alu_zero = 0; rs_data = '0;
  endtask

  logic [5:0] ops [8] = '{OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW};

  localparam logic [31:0] W_J40  = {OP_J, 26'h10};
  localparam logic [31:0] W_BEQ  = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
  localparam logic [31:0] W_BNE  = {OP_BNE, 5'd1, 5'd2, 16'h0003};
  localparam logic [31:0] W_JR   = {OP_RTYPE, 5'd31, 15'd0, FUNCT_JR};
  localparam logic [31:0] W_JAL  = {OP_JAL, 26'h10};
  localparam logic [31:0] W_ADDI = {OP_ADDI, 5'd8, 5'd8, 16'h0005};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_pc", pc, 32'h0);
    check("rst_im_req", 32'(im_req), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    // Nops acked immediately: fetch every second cycle.
    rst_n = 1'b1; im_ack = 1'b1; im_rdata = 32'h0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      check("nop_req", 32'(im_req), 32'(i % 2 == 0));
      check("nop_valid", 32'(instr_valid), 32'(i % 2 == 1));
      if (i % 2 == 0) check("nop_addr", im_addr, 32'(i * 2));
      @(posedge clk); #1;
    end
    im_ack = 1'b0;

    do_fetch(W_J40, 32'h10, 1'b1, "j_from_10");
    do_exec(1, 0, 0, 0, 0, 0, 0);
    do_fetch(W_BEQ, 32'h40, 1'b1, "beq_at_40");
    do_exec(0, 1, 0, 0, 0, 1, 0);
    do_fetch(W_J40, 32'h3C, 1'b1, "beq_taken_3c");
    do_exec(1, 0, 0, 0, 0, 0, 0);
    do_fetch(W_BEQ, 32'h40, 1'b1, "beq_at_40b");
    do_exec(0, 1, 0, 0, 0, 0, 0);
    do_fetch(W_J40, 32'h44, 1'b1, "beq_not_taken_44");
    do_exec(1, 0, 0, 0, 0, 0, 0);
    do_fetch(W_BNE, 32'h40, 1'b1, "bne_at_40");
    do_exec(0, 1, 1, 0, 0, 0, 0);
    do_fetch(W_JR, 32'h50, 1'b1, "bne_taken_50");
    do_exec(1, 0, 0, 0, 1, 0, 32'h1000_0008);
    do_fetch(W_JAL, 32'h1000_0008, 1'b1, "jr_beats_jump");
    check("jal_link", link_addr, 32'h1000_000C);
    do_exec(1, 0, 0, 1, 0, 0, 0);
    do_fetch(W_JR, 32'h1000_0040, 1'b1, "jal_target");
    check("err_before_jr", 32'(err), 32'h0);
    do_exec(0, 0, 0, 0, 1, 0, 32'h0000_0103);
    check("err_misaligned_jr", 32'(err), 32'h1);
    do_fetch(W_ADDI, 32'h100, 1'b1, "jr_aligned_100");
    stall = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_pc", pc, 32'h100);
      check("stall_instr", instr, W_ADDI);
      check("stall_valid", 32'(instr_valid), 32'h1);
    end
    do_exec(0, 0, 0, 0, 0, 0, 0);
    do_fetch(32'h0, 32'h104, 1'b1, "after_stall_104");

    for (int c = 0; c < 400; c++) begin
      im_ack   = ($urandom_range(0, 2) == 0);
      im_rdata = {ops[$urandom_range(0, 7)], 26'($urandom)};
      if ($urandom_range(0, 3) == 0) im_rdata[5:0] = FUNCT_JR;
      Jump     = ($urandom_range(0, 3) == 0);
      Jal      = Jump & 1'($urandom);
      Branch   = 1'($urandom);
      NEqual   = 1'($urandom);
      Jr       = ($urandom_range(0, 3) == 0);
      alu_zero = 1'($urandom);
      rs_data  = $urandom;
      stall    = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    im_ack = 0; stall = 0; Jump = 0; Jal = 0; Branch = 0; NEqual = 0; Jr = 0; alu_zero = 0;

    // Fresh FETCH, then withhold im_ack.
    do_fetch(32'h0, 32'h0, 1'b0, "pre_timeout");
    do_exec(0, 0, 0, 0, 0, 0, 0);
    check("tmo_start_req", 32'(im_req), 32'h1);
    repeat (TMO - 1) begin @(posedge clk); #1; end
    check("tmo_not_yet", 32'(im_req), 32'h1);
    @(posedge clk); #1;
    check("tmo_req_dropped", 32'(im_req), 32'h0);
    check("tmo_err", 32'(err), 32'h1);
    check("tmo_no_valid", 32'(instr_valid), 32'h0);
    im_ack = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("error_ignores_ack", 32'(im_req), 32'h0);
    im_ack = 1'b0;

    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_clears_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    do_fetch(W_J40, 32'h0, 1'b1, "post_rst_fetch0");
    do_exec(1, 0, 0, 0, 0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("mid_fetch_pc", pc, 32'h40);
    check("mid_fetch_req", 32'(im_req), 32'h1);
    rst_n = 1'b0;
    #2;
    check("async_rst_req", 32'(im_req), 32'h0);
    check("async_rst_pc", pc, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
